// File: rtl/zvc_stream_compressor.sv
// Two-stage valid/ready zero-value compressor: lanes whose mapping-table entry is zero are
// squeezed out and the survivors packed toward lane 0. Optional: ZVC_EMPTY_DROP_EN.
module zvc_stream_compressor #(
    parameter  int LINE_SIZE     = 128,
    parameter  int WORD_WIDTH    = 8,
    parameter  int DIST_WIDTH    = 7,
    parameter  int MAX_LIFM_RSIZ = 4,
    localparam int MT_W          = DIST_WIDTH * MAX_LIFM_RSIZ,
    localparam int CNT_WIDTH     = $clog2(LINE_SIZE) + 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_line,
    input  logic [LINE_SIZE*MT_W-1:0]       mt_line,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_comp,
    output logic [LINE_SIZE*MT_W-1:0]       mt_comp,
    output logic [CNT_WIDTH-1:0]            comp_cnt
);

    logic                            v1, v2, ready1, ready2;
    logic [LINE_SIZE*WORD_WIDTH-1:0] lifm1, lifm_n;
    logic [LINE_SIZE*MT_W-1:0]       mt1, mt_n;
    logic [LINE_SIZE-1:0]            mask_n, mask1;
    logic [CNT_WIDTH-1:0]            pre_n [LINE_SIZE];
    logic [CNT_WIDTH-1:0]            pre1  [LINE_SIZE];
    logic [CNT_WIDTH-1:0]            cnt_n;
    logic                            keep_n;

    assign ready2    = !v2 || out_ready;
    assign ready1    = !v1 || ready2;
    assign in_ready  = ready1;
    assign out_valid = v2;

    // Stage 1: bubble mask and exclusive count of bubbles below each lane.
    always_comb begin
        logic [CNT_WIDTH-1:0] acc;
        acc    = '0;
        mask_n = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            mask_n[i] = (mt_line[i*MT_W +: MT_W] == '0);
            pre_n[i]  = acc;
            acc       = acc + CNT_WIDTH'(mask_n[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) v1 <= 1'b0;
        else if (ready1) v1 <= in_valid;
    end

    // Data registers need no reset: they are only observed through v1.
    always_ff @(posedge clk) begin
        if (ready1 && in_valid) begin
            lifm1 <= lifm_line;
            mt1   <= mt_line;
            mask1 <= mask_n;
            pre1  <= pre_n;
        end
    end

    // Stage 2: scatter each kept lane to i - bubbles_below(i); unwritten positions stay zero.
    always_comb begin
        int d;
        d      = 0;
        lifm_n = '0;
        mt_n   = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            if (!mask1[i]) begin
                d = i - int'(pre1[i]);
                lifm_n[d*WORD_WIDTH +: WORD_WIDTH] = lifm1[i*WORD_WIDTH +: WORD_WIDTH];
                mt_n[d*MT_W +: MT_W]               = mt1[i*MT_W +: MT_W];
            end
        end
        cnt_n = CNT_WIDTH'(LINE_SIZE) - pre1[LINE_SIZE-1] - CNT_WIDTH'(mask1[LINE_SIZE-1]);
    end

`ifdef ZVC_EMPTY_DROP_EN
    assign keep_n = v1 && (cnt_n != '0);
`else
    assign keep_n = v1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2        <= 1'b0;
            lifm_comp <= '0;
            mt_comp   <= '0;
            comp_cnt  <= '0;
        end else if (ready2) begin
            v2 <= keep_n;
            if (v1) begin
                lifm_comp <= lifm_n;
                mt_comp   <= mt_n;
                comp_cnt  <= cnt_n;
            end
        end
    end

endmodule

// File: tb/tb_zvc_stream_compressor.sv
// Directed bench for zvc_stream_compressor: vector table streamed through the block plus
// hand-written stall, reset and empty-line sequences.
module tb_zvc_stream_compressor;
    localparam int LS = 128, WW = 8, MTW = 28, CW = 8;
    localparam int LW = LS * WW, MW = LS * MTW;
`ifdef ZVC_EMPTY_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    typedef struct {
        logic [LW-1:0] lifm;
        logic [MW-1:0] mt;
        logic [LW-1:0] e_lifm;
        logic [MW-1:0] e_mt;
        logic [CW-1:0] e_cnt;
    } vec_t;

    logic          clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic          in_ready, out_valid;
    logic [LW-1:0] lifm_line = '0, lifm_comp;
    logic [MW-1:0] mt_line = '0, mt_comp;
    logic [CW-1:0] comp_cnt;

    vec_t tbl[14];
    int   errors = 0, checks = 0, cyc = 0, waited = 0, n_out = 0, base;
    bit   lat_chk = 1'b0;
    int   expq[$], cycq[$];

    zvc_stream_compressor dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .lifm_line(lifm_line), .mt_line(mt_line), .out_valid(out_valid),
        .out_ready(out_ready), .lifm_comp(lifm_comp), .mt_comp(mt_comp),
        .comp_cnt(comp_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_lifm(input string nm, input logic [LW-1:0] a, input logic [LW-1:0] e);
        checks++;
        if (a !== e) begin
            int idx = 0;
            errors++;
            for (int i = LS - 1; i >= 0; i--) if (a[i*WW +: WW] !== e[i*WW +: WW]) idx = i;
            $display("FAIL %s lane %0d: got %0h want %0h", nm, idx, a[idx*WW +: WW], e[idx*WW +: WW]);
        end
    endtask

    task automatic chk_mt(input string nm, input logic [MW-1:0] a, input logic [MW-1:0] e);
        checks++;
        if (a !== e) begin
            int idx = 0;
            errors++;
            for (int i = LS - 1; i >= 0; i--) if (a[i*MTW +: MTW] !== e[i*MTW +: MTW]) idx = i;
            $display("FAIL %s lane %0d: got %0h want %0h", nm, idx, a[idx*MTW +: MTW], e[idx*MTW +: MTW]);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send(input int k);
        lifm_line = tbl[k].lifm;
        mt_line   = tbl[k].mt;
        in_valid  = 1'b1;
        for (int t = 0; t < 100; t++) begin
            #1;
            if (in_ready) begin
                if (!(DROP && tbl[k].e_cnt == 0)) begin
                    expq.push_back(k);
                    cycq.push_back(cyc);
                end
                @(negedge clk);
                return;
            end
            waited++;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL send_timeout: line %0d got not-accepted want accepted", k);
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && expq.size() != 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("drain_pending", expq.size(), 0);
    endtask

    // Output monitor: every output handshake is matched against the next expected line.
    always @(negedge clk) begin
        #2;
        if (reset_n && out_valid && out_ready) begin
            n_out++;
            if (expq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out: got cnt %0d want no output", comp_cnt);
            end else begin
                int k, c;
                k = expq.pop_front();
                c = cycq.pop_front();
                chk_lifm("out_lifm", lifm_comp, tbl[k].e_lifm);
                chk_mt("out_mt", mt_comp, tbl[k].e_mt);
                chk("out_cnt", 32'(comp_cnt), 32'(tbl[k].e_cnt));
                if (lat_chk) chk("latency", cyc - c, 2);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vector table: 0..9 dense, 10 alternating, 11 single lane 127, 12 upper half, 13 empty.
        for (int n = 0; n < 14; n++) begin
            tbl[n].lifm = '0; tbl[n].mt = '0; tbl[n].e_lifm = '0; tbl[n].e_mt = '0;
        end
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < LS; i++) begin
                tbl[n].lifm[i*WW +: WW]  = 8'($urandom);
                tbl[n].mt[i*MTW +: MTW]  = MTW'($urandom) | (MTW'(1) << (i % MTW));
            end
            tbl[n].e_lifm = tbl[n].lifm;
            tbl[n].e_mt   = tbl[n].mt;
            tbl[n].e_cnt  = 8'd128;
        end
        for (int i = 0; i < LS; i++) begin
            tbl[10].lifm[i*WW +: WW] = 8'(i) ^ 8'h5A;
            tbl[10].mt[i*MTW +: MTW] = (i % 2 == 1) ? MTW'(i * 3 + 1) : '0;
        end
        for (int k = 0; k < 64; k++) begin
            tbl[10].e_lifm[k*WW +: WW]  = tbl[10].lifm[(2*k+1)*WW +: WW];
            tbl[10].e_mt[k*MTW +: MTW]  = tbl[10].mt[(2*k+1)*MTW +: MTW];
        end
        tbl[10].e_cnt = 8'd64;
        for (int i = 0; i < LS; i++) tbl[11].lifm[i*WW +: WW] = 8'($urandom) | 8'h01;
        tbl[11].lifm[127*WW +: WW] = 8'hA5;
        tbl[11].mt[127*MTW +: MTW] = 28'h1234567;
        tbl[11].e_lifm[7:0]        = 8'hA5;
        tbl[11].e_mt[MTW-1:0]      = 28'h1234567;
        tbl[11].e_cnt              = 8'd1;
        for (int i = 0; i < LS; i++) begin
            tbl[12].lifm[i*WW +: WW] = (i < 64) ? 8'hFF : 8'(i);
            tbl[12].mt[i*MTW +: MTW] = (i < 64) ? '0 : MTW'((i << 4) | 3);
        end
        for (int k = 0; k < 64; k++) begin
            tbl[12].e_lifm[k*WW +: WW]  = 8'(k + 64);
            tbl[12].e_mt[k*MTW +: MTW]  = MTW'(((k + 64) << 4) | 3);
        end
        tbl[12].e_cnt = 8'd64;
        for (int i = 0; i < LS; i++) tbl[13].lifm[i*WW +: WW] = 8'($urandom) | 8'h80;
        tbl[13].e_cnt = 8'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_cnt", 32'(comp_cnt), 0);
        chk_lifm("rst_lifm", lifm_comp, '0);
        chk_mt("rst_mt", mt_comp, '0);
        reset_n = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);

        // Back-to-back dense lines, then the sparse patterns, unstalled
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        waited    = 0;
        for (int k = 0; k < 10; k++) send(k);
        chk("dense_in_ready_waits", waited, 0);
        for (int k = 10; k < 14; k++) send(k);
        in_valid = 1'b0;
        drain();
        lat_chk = 1'b0;

        // Backpressure: two accepts fill the pipe, then in_ready drops and S2 holds
        out_ready = 1'b0;
        send(10);
        send(11);
        lifm_line = tbl[12].lifm;
        mt_line   = tbl[12].mt;
        in_valid  = 1'b1;
        for (int t = 0; t < 4; t++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_out_valid", 32'(out_valid), 1);
            chk_lifm("stall_lifm", lifm_comp, tbl[10].e_lifm);
            chk("stall_cnt", 32'(comp_cnt), 32'(tbl[10].e_cnt));
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(12);
        send(0);
        in_valid = 1'b0;
        drain();

        // Asynchronous reset with two lines in flight
        out_ready = 1'b0;
        send(1);
        send(2);
        in_valid = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_cnt", 32'(comp_cnt), 0);
        chk_lifm("arst_lifm", lifm_comp, '0);
        chk_mt("arst_mt", mt_comp, '0);
        expq.delete();
        cycq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("arst_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("arst_no_stale", 32'(out_valid), 0);

        // Empty line between two dense lines
        base = n_out;
        send(3);
        send(13);
        send(4);
        in_valid = 1'b0;
        drain();
        chk("empty_mid_outputs", n_out - base, DROP ? 2 : 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
